// File: rtl/period_select_pkg.sv
// Shared constants for the period selector: FSM state encoding and counter widths.
package period_select_pkg;

  localparam int PERIOD_W = 2;
  localparam int DCNT_W   = 8;
  localparam int HCNT_W   = 16;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

endpackage

// File: rtl/period_select_key_sync.sv
// Two-flop synchronizer for the raw push-button; both flops reset to the released level (1).
module key_sync (
  input  logic clock,
  input  logic reset,
  input  logic key_in,
  output logic key_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = key_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign key_out = sync_q;

endmodule

// File: rtl/period_select.sv
// Debounced push-button that steps a 2-bit heartbeat period code; a long hold resets it to 0.
module period_select
  import period_select_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int LONG_CYCLES     = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_key,
  output logic [PERIOD_W-1:0] io_period,
  output logic                io_step,
  output logic                io_long,
  output logic                io_held
);

  // dcnt counts stable samples already seen, so the current sample is the last one at DEBOUNCE_CYCLES-1
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_LONG = HCNT_W'(LONG_CYCLES);
  localparam logic [HCNT_W-1:0] HCNT_PRE  = HCNT_W'(LONG_CYCLES - 1);

  logic                skey;
  logic [1:0]          state_q, state_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                step_q, step_d;
  logic                long_q, long_d;
  logic                single_sample;

  key_sync u_key_sync (
    .clock   (clock),
    .reset   (reset),
    .key_in  (io_key),
    .key_out (skey)
  );

  assign single_sample = (DCNT_LAST == '0);

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    step_d   = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!skey) begin
          if (single_sample) begin
            state_d  = ST_HELD;
            dcnt_d   = '0;
            hcnt_d   = '0;
            period_d = period_q + 2'd1;
            step_d   = 1'b1;
          end else begin
            state_d = ST_PRESS_WAIT;
            dcnt_d  = 8'd1;
          end
        end
      end
      ST_PRESS_WAIT: begin
        if (skey) begin
          state_d = ST_IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d  = ST_HELD;
          dcnt_d   = '0;
          hcnt_d   = '0;
          period_d = period_q + 2'd1;
          step_d   = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end
      ST_HELD: begin
        if (skey) begin
          if (single_sample) begin
            state_d = ST_IDLE;
            dcnt_d  = '0;
            hcnt_d  = '0;
          end else begin
            state_d = ST_RELEASE_WAIT;
            dcnt_d  = 8'd1;
          end
        end else if (hcnt_q != HCNT_LONG) begin
          // Saturating at LONG_CYCLES is what makes the long pulse fire only once per press
          hcnt_d = hcnt_q + 16'd1;
          if (hcnt_q == HCNT_PRE) begin
            period_d = '0;
            long_d   = 1'b1;
          end
        end
      end
      default: begin
        if (!skey) begin
          state_d = ST_HELD;
          dcnt_d  = '0;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = ST_IDLE;
          dcnt_d  = '0;
          hcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      dcnt_q   <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      step_q   <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      step_q   <= step_d;
      long_q   <= long_d;
    end
  end

  assign io_period = period_q;
  assign io_step   = step_q;
  assign io_long   = long_q;
  assign io_held   = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);

endmodule

// File: doc/period_select.md
PERIOD_SELECT -- requirements
Module: period_select

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 3, giving the number of consecutive stable synchronized samples (range 1..255) needed to accept a press or a release.
REQ-002 SHALL have parameter LONG_CYCLES, default 10, giving the HELD-state cycles (range DEBOUNCE_CYCLES+1..65535) that make a long press.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 io_key  in  1  raw push-button, active-low (0 = pressed), asynchronous to clock.
REQ-006 io_period  out  2  selected heartbeat period code; drives the HeartBeat io_period input directly.
REQ-007 io_step  out  1  one-cycle pulse on each accepted press.
REQ-008 io_long  out  1  one-cycle pulse when a long press is detected.
REQ-009 io_held  out  1  debounced key level, 1 while the FSM is in HELD or RELEASE_WAIT.

Function
REQ-010 io_key SHALL pass through a 2-flop synchronizer; only the second flop output (skey) SHALL be used.
REQ-011 FSM states SHALL be IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, with a debounce counter dcnt (8 bit) and a hold counter hcnt (16 bit, saturating).
REQ-012 IDLE: skey=0 -> PRESS_WAIT with dcnt=1; otherwise stay.
REQ-013 PRESS_WAIT: skey=1 -> IDLE with dcnt=0; skey=0 and dcnt=DEBOUNCE_CYCLES -> HELD, hcnt=0, io_period increments, io_step=1; otherwise dcnt increments.
REQ-014 Accept latency: with the first edge sampling io_key=0 counted as edge 0, io_period and io_step SHALL update at edge DEBOUNCE_CYCLES+1 (edge 4 by default).
REQ-015 io_period increments SHALL wrap modulo 4 (3 -> 0).
REQ-016 HELD: hcnt SHALL increment each cycle up to LONG_CYCLES and then saturate.
REQ-017 On the edge where hcnt reaches LONG_CYCLES, io_period SHALL become 0 and io_long SHALL be 1, exactly once per press.
REQ-018 HELD: skey=1 -> RELEASE_WAIT with dcnt=1.
REQ-019 RELEASE_WAIT: skey=0 -> HELD with no increment and no io_step; hcnt SHALL be frozen while in RELEASE_WAIT and resume from its value on return.
REQ-020 RELEASE_WAIT: skey=1 and dcnt=DEBOUNCE_CYCLES -> IDLE with hcnt=0; otherwise dcnt increments.
REQ-021 A glitch low for fewer than DEBOUNCE_CYCLES samples SHALL cause no io_period change.
REQ-022 io_step and io_long SHALL never be 1 on the same cycle; both SHALL be registered outputs.

Reset
REQ-023 When reset=0 at an edge: state=IDLE, dcnt=0, hcnt=0, both synchronizer flops=1, io_period=0, io_step=0, io_long=0, io_held=0.
REQ-024 Reset asserted mid-press SHALL abort the press; if the key is still low after reset deasserts, it SHALL be treated as a new press from IDLE and increment io_period once debounced.

Structure
REQ-025 A shared package SHALL hold the state enum encoding (2 bit) and PERIOD_W=2.
REQ-026 The synchronizer SHALL be a sub-module named key_sync (2 flops, reset value 1); the FSM and counters SHALL stay in period_select.

Verification
REQ-027 Clean press: io_key low for 6 cycles from reset state -> io_period 0->1 at edge 4, one io_step pulse, no io_long.
REQ-028 Wrap: 4 clean presses separated by 6 released cycles -> io_period sequence 1,2,3,0 and exactly 4 io_step pulses.
REQ-029 Glitch: io_key low for 2 cycles, then high -> io_period unchanged, no pulses.
REQ-030 Long press: io_period=2, io_key held low for 20 cycles -> increments to 3, then 0 with a single io_long pulse 10 cycles after entering HELD; release -> no further change.
REQ-031 Release bounce: io_key high for 1 cycle during HELD, then low again -> no second io_step, and hcnt resumes.
REQ-032 Reset mid-press: assert reset during PRESS_WAIT with io_key low, then deassert while still low -> io_period=0, then 1 after debounce.
